// File: rtl/fft_sample_store.sv
`default_nettype none
// ============================================================================
// Module  : fft_sample_store
// Purpose : FFT sample memory handed between the AXI bridge (load, readout) and
//           the FFT core (in-place calculation), with ownership sequencing.
// Rev     : 1.0
// ============================================================================
module fft_sample_store #(
  parameter int LOG2_N     = 10,
  parameter int DATA_WIDTH = 32,
  parameter bit BITREV     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [15:0]           i_SAMPLE,
  input  logic [11:0]           i_SAMPLE_INDEX,
  input  logic                  i_WRITE,
  input  logic                  i_READ,
  input  logic                  i_DATA_LOADED,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_CALC_END,
  output logic                  o_START,
  input  logic [LOG2_N-1:0]     i_CORE_ADDR,
  input  logic                  i_CORE_WE,
  input  logic [DATA_WIDTH-1:0] i_CORE_WDATA,
  output logic [DATA_WIDTH-1:0] o_CORE_RDATA,
  input  logic                  i_CORE_DONE,
  output logic [LOG2_N:0]       o_SAMPLE_COUNT,
  output logic                  o_ERR,
  output logic [1:0]            o_state
);

  localparam int              C_N        = 1 << LOG2_N;
  localparam logic [LOG2_N:0] C_N_CNT    = (LOG2_N + 1)'(C_N);
  localparam logic [11:0]     C_LAST_IDX = 12'(C_N - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_CALC   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [LOG2_N:0]         count_q, count_d;
  logic                    err_q, err_d;
  logic                    start_q, start_d;
  logic                    calc_end_q, calc_end_d;
  logic [DATA_WIDTH-1:0]   core_rdata_q;
  logic [DATA_WIDTH-1:0]   mem_q [C_N];

  logic [LOG2_N-1:0]       w_idx_low;
  logic [LOG2_N-1:0]       w_idx_rev;
  logic [LOG2_N-1:0]       w_bridge_waddr;
  logic                    w_idx_in_range;
  logic                    w_mem_we;
  logic [LOG2_N-1:0]       w_mem_waddr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;

  assign w_idx_low      = i_SAMPLE_INDEX[LOG2_N-1:0];
  assign w_idx_in_range = (i_SAMPLE_INDEX >> LOG2_N) == 12'd0;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2_N; gi++) begin : g_bitrev
      assign w_idx_rev[gi] = w_idx_low[LOG2_N-1-gi];
    end
  endgenerate

  assign w_bridge_waddr = BITREV ? w_idx_rev : w_idx_low;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_d       = err_q;
    w_mem_we    = 1'b0;
    w_mem_waddr = w_bridge_waddr;
    w_mem_wdata = {i_SAMPLE, {(DATA_WIDTH-16){1'b0}}};
    case (state_q)
      S_LOAD: begin
        if (i_WRITE) begin
          if (w_idx_in_range) begin
            w_mem_we = 1'b1;
            if (count_q != C_N_CNT) count_d = count_q + (LOG2_N + 1)'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        // Completeness is judged including a write in the same cycle.
        if (i_DATA_LOADED) begin
          state_d = S_CALC;
          if (count_d != C_N_CNT) err_d = 1'b1;
        end
      end
      S_CALC: begin
        w_mem_we    = i_CORE_WE;
        w_mem_waddr = i_CORE_ADDR;
        w_mem_wdata = i_CORE_WDATA;
        if (i_WRITE || i_READ) err_d = 1'b1;
        if (i_CORE_DONE) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (i_CORE_WE) err_d = 1'b1;
        if (i_READ && (i_SAMPLE_INDEX == C_LAST_IDX)) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
    start_d    = (state_q == S_LOAD) && (state_d == S_CALC);
    calc_end_d = (state_d == S_RESULT);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= S_LOAD;
      count_q      <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      calc_end_q   <= 1'b0;
      core_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_q      <= err_d;
      start_q    <= start_d;
      calc_end_q <= calc_end_d;
      if (state_q == S_CALC) core_rdata_q <= mem_q[i_CORE_ADDR];
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) mem_q[w_mem_waddr] <= w_mem_wdata;
  end

  assign o_DATA         = (state_q == S_RESULT) ? mem_q[w_idx_low] : '0;
  assign o_CALC_END     = calc_end_q;
  assign o_START        = start_q;
  assign o_CORE_RDATA   = core_rdata_q;
  assign o_SAMPLE_COUNT = count_q;
  assign o_ERR          = err_q;
  assign o_state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_store.sv
`default_nettype none
// Testbench for fft_sample_store (LOG2_N=3, BITREV=1): scenario tasks checked
// against a behavioural model of memory contents, count, error and state.
module tb_fft_sample_store;
  localparam int         LOG2_N = 3;
  localparam int         N      = 8;
  localparam int         DW     = 32;
  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic [15:0]       i_SAMPLE;
  logic [11:0]       i_SAMPLE_INDEX;
  logic              i_WRITE, i_READ, i_DATA_LOADED;
  logic [DW-1:0]     o_DATA;
  logic              o_CALC_END, o_START;
  logic [LOG2_N-1:0] i_CORE_ADDR;
  logic              i_CORE_WE;
  logic [DW-1:0]     i_CORE_WDATA, o_CORE_RDATA;
  logic              i_CORE_DONE;
  logic [LOG2_N:0]   o_SAMPLE_COUNT;
  logic              o_ERR;
  logic [1:0]        o_state;

  always #5 i_clk = ~i_clk;

  fft_sample_store #(.LOG2_N(LOG2_N), .DATA_WIDTH(DW), .BITREV(1'b1)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_SAMPLE(i_SAMPLE), .i_SAMPLE_INDEX(i_SAMPLE_INDEX),
    .i_WRITE(i_WRITE), .i_READ(i_READ), .i_DATA_LOADED(i_DATA_LOADED),
    .o_DATA(o_DATA), .o_CALC_END(o_CALC_END), .o_START(o_START),
    .i_CORE_ADDR(i_CORE_ADDR), .i_CORE_WE(i_CORE_WE), .i_CORE_WDATA(i_CORE_WDATA),
    .o_CORE_RDATA(o_CORE_RDATA), .i_CORE_DONE(i_CORE_DONE),
    .o_SAMPLE_COUNT(o_SAMPLE_COUNT), .o_ERR(o_ERR), .o_state(o_state)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] ref_mem [N];
  int            exp_count;
  bit            exp_err;
  logic [1:0]    exp_state;

  function automatic int brev(input int idx);
    int r = 0;
    for (int k = 0; k < LOG2_N; k++) r = r * 2 + ((idx >> k) & 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_SAMPLE = '0; i_SAMPLE_INDEX = '0; i_WRITE = 1'b0; i_READ = 1'b0;
    i_DATA_LOADED = 1'b0; i_CORE_ADDR = '0; i_CORE_WE = 1'b0;
    i_CORE_WDATA = '0; i_CORE_DONE = 1'b0;
  endtask

  task automatic model_reset();
    exp_state = LOAD; exp_count = 0; exp_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    model_reset();
  endtask

  task automatic bridge_write(input int idx, input logic [15:0] sample, input bit loaded);
    i_SAMPLE_INDEX = 12'(idx); i_SAMPLE = sample; i_WRITE = 1'b1; i_DATA_LOADED = loaded;
    tick();
    i_WRITE = 1'b0; i_DATA_LOADED = 1'b0;
    if (exp_state == LOAD) begin
      if (idx < N) begin
        ref_mem[brev(idx)] = {sample, 16'h0000};
        if (exp_count < N) exp_count++;
      end else begin
        exp_err = 1'b1;
      end
      if (loaded) begin
        if (exp_count < N) exp_err = 1'b1;
        exp_state = CALC;
      end
    end else if (exp_state == CALC) begin
      exp_err = 1'b1;
    end
  endtask

  task automatic core_access(input int addr, input bit we, input logic [DW-1:0] data,
                             output logic [DW-1:0] exp_rd);
    exp_rd = ref_mem[addr];
    i_CORE_ADDR = 3'(addr); i_CORE_WE = we; i_CORE_WDATA = data;
    tick();
    i_CORE_WE = 1'b0;
    if (exp_state == CALC && we) ref_mem[addr] = data;
    else if (exp_state == RESULT && we) exp_err = 1'b1;
  endtask

  task automatic core_done();
    i_CORE_DONE = 1'b1;
    tick();
    i_CORE_DONE = 1'b0;
    if (exp_state == CALC) exp_state = RESULT;
  endtask

  task automatic load_full();
    int p [N];
    for (int i = 0; i < N; i++) p[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = p[i];
      p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < N; i++) bridge_write(p[i], 16'($urandom), i == N - 1);
  endtask

  task automatic readout_exit();
    i_SAMPLE_INDEX = 12'(N - 1); i_READ = 1'b1;
    tick();
    i_READ = 1'b0;
    exp_state = LOAD; exp_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_state, o_START, o_CALC_END, o_SAMPLE_COUNT, o_ERR} !== {LOAD, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d start=%b calc_end=%b count=%0d err=%b, required 0/0/0/0/0",
               o_state, o_START, o_CALC_END, o_SAMPLE_COUNT, o_ERR);
    end
    n_checks++;
    if (o_CORE_RDATA !== '0 || o_DATA !== '0) begin
      n_fail++;
      $display("FAIL reset_data: core_rdata=%h data=%h, required 0/0", o_CORE_RDATA, o_DATA);
    end
  endtask

  task automatic test_load();
    logic [DW-1:0] rd;
    do_reset();
    for (int i = 0; i < N; i++) begin
      bridge_write(i, 16'((i + 1) * 16'h0101), i == N - 1);
      n_checks++;
      if (o_SAMPLE_COUNT !== 4'(exp_count) || o_state !== exp_state || o_START !== (i == N - 1)) begin
        n_fail++;
        $display("FAIL load_step%0d: count=%0d state=%0d start=%b, required %0d/%0d/%b",
                 i, o_SAMPLE_COUNT, o_state, o_START, exp_count, exp_state, i == N - 1);
      end
    end
    tick();
    n_checks++;
    if (o_START !== 1'b0 || o_state !== CALC || o_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL start_pulse: start=%b state=%0d err=%b, required 0/1/0", o_START, o_state, o_ERR);
    end
    for (int a = 0; a < N; a++) begin
      core_access(a, 1'b0, '0, rd);
      n_checks++;
      if (o_CORE_RDATA !== rd) begin
        n_fail++;
        $display("FAIL bitrev_mem%0d: got %h required %h", a, o_CORE_RDATA, rd);
      end
    end
  endtask

  task automatic test_calc();
    logic [DW-1:0] rd;
    core_access(3, 1'b1, 32'hDEADBEEF, rd);
    n_checks++;
    if (o_CORE_RDATA !== rd) begin
      n_fail++;
      $display("FAIL read_before_write: got %h required %h", o_CORE_RDATA, rd);
    end
    core_access(3, 1'b0, '0, rd);
    n_checks++;
    if (o_CORE_RDATA !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL core_readback: got %h required deadbeef", o_CORE_RDATA);
    end
    for (int i = 0; i < 12; i++) begin
      core_access($urandom_range(0, N - 1), 1'($urandom), $urandom, rd);
      n_checks++;
      if (o_CORE_RDATA !== rd) begin
        n_fail++;
        $display("FAIL core_rand%0d: got %h required %h", i, o_CORE_RDATA, rd);
      end
    end
    i_DATA_LOADED = 1'b1;
    tick();
    i_DATA_LOADED = 1'b0;
    n_checks++;
    if (o_state !== CALC || o_DATA !== '0 || o_CALC_END !== 1'b0) begin
      n_fail++;
      $display("FAIL calc_hold: state=%0d data=%h calc_end=%b, required 1/0/0", o_state, o_DATA, o_CALC_END);
    end
    core_done();
    n_checks++;
    if (o_state !== RESULT || o_CALC_END !== 1'b1 || o_START !== 1'b0) begin
      n_fail++;
      $display("FAIL core_done: state=%0d calc_end=%b start=%b, required 2/1/0", o_state, o_CALC_END, o_START);
    end
  endtask

  task automatic test_result();
    for (int i = 0; i < N - 1; i++) begin
      int idx = $urandom_range(0, N - 2);
      i_SAMPLE_INDEX = 12'(idx); i_READ = 1'($urandom);
      #1;
      n_checks++;
      if (o_DATA !== ref_mem[idx]) begin
        n_fail++;
        $display("FAIL result_read idx%0d: got %h required %h", idx, o_DATA, ref_mem[idx]);
      end
      tick();
    end
    i_READ = 1'b1; i_SAMPLE_INDEX = 12'd15; i_DATA_LOADED = 1'b1; i_CORE_DONE = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (o_state !== RESULT || o_CALC_END !== 1'b1 || o_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL result_hold: state=%0d calc_end=%b err=%b, required 2/1/0", o_state, o_CALC_END, o_ERR);
    end
    i_SAMPLE_INDEX = 12'(N - 1); i_READ = 1'b1;
    #1;
    n_checks++;
    if (o_DATA !== ref_mem[N - 1]) begin
      n_fail++;
      $display("FAIL result_last: got %h required %h", o_DATA, ref_mem[N - 1]);
    end
    readout_exit();
    n_checks++;
    if ({o_state, o_CALC_END, o_SAMPLE_COUNT, o_ERR} !== {LOAD, 1'b0, 4'd0, exp_err} || o_DATA !== '0) begin
      n_fail++;
      $display("FAIL result_exit: state=%0d calc_end=%b count=%0d err=%b data=%h, required 0/0/0/%b/0",
               o_state, o_CALC_END, o_SAMPLE_COUNT, o_ERR, o_DATA, exp_err);
    end
  endtask

  task automatic test_bad_index();
    int order [N] = '{0, 2, 3, 4, 5, 6, 7, 0};
    logic [DW-1:0] rd;
    bridge_write(9, 16'hBAD9, 1'b0);
    bridge_write($urandom_range(N, 4095), 16'($urandom), 1'b0);
    n_checks++;
    if (o_ERR !== 1'b1 || o_SAMPLE_COUNT !== 4'd0 || o_state !== LOAD) begin
      n_fail++;
      $display("FAIL bad_index: err=%b count=%0d state=%0d, required 1/0/0", o_ERR, o_SAMPLE_COUNT, o_state);
    end
    for (int i = 0; i < N; i++) begin
      bridge_write(order[i], 16'($urandom), i == N - 1);
      n_checks++;
      if (o_ERR !== 1'b1 || o_SAMPLE_COUNT !== 4'(exp_count)) begin
        n_fail++;
        $display("FAIL err_sticky%0d: err=%b count=%0d, required 1/%0d", i, o_ERR, o_SAMPLE_COUNT, exp_count);
      end
    end
    for (int a = 0; a < N; a++) begin
      core_access(a, 1'b0, '0, rd);
      n_checks++;
      if (o_CORE_RDATA !== rd) begin
        n_fail++;
        $display("FAIL bad_index_mem%0d: got %h required %h", a, o_CORE_RDATA, rd);
      end
    end
    core_done();
    readout_exit();
    n_checks++;
    if (o_ERR !== 1'b1 || o_state !== LOAD) begin
      n_fail++;
      $display("FAIL err_after_cycle: err=%b state=%0d, required 1/0", o_ERR, o_state);
    end
  endtask

  task automatic test_err_sources();
    logic [DW-1:0] rd;
    logic [DW-1:0] want;
    for (int kind = 0; kind < 4; kind++) begin
      do_reset();
      if (kind == 3) begin
        for (int i = 0; i < 5; i++) bridge_write(i, 16'($urandom), i == 4);
      end else begin
        load_full();
        n_checks++;
        if (o_ERR !== 1'b0) begin
          n_fail++;
          $display("FAIL err_clean kind%0d: err=%b required 0", kind, o_ERR);
        end
      end
      want = '0; rd = '0;
      case (kind)
        0: begin
          bridge_write(0, 16'hFFFF, 1'b0);
          core_access(brev(0), 1'b0, '0, rd);
          want = o_CORE_RDATA;
        end
        1: begin
          i_READ = 1'b1; i_SAMPLE_INDEX = 12'(N - 1);
          tick();
          i_READ = 1'b0;
          exp_err = 1'b1;
        end
        2: begin
          core_done();
          core_access(2, 1'b1, ~ref_mem[2], rd);
          i_SAMPLE_INDEX = 12'd2;
          #1;
          want = o_DATA; rd = ref_mem[2];
        end
        default: ;
      endcase
      n_checks++;
      if (o_ERR !== 1'b1 || o_ERR !== exp_err || o_state !== exp_state) begin
        n_fail++;
        $display("FAIL err_source kind%0d: err=%b state=%0d, required 1/%0d", kind, o_ERR, o_state, exp_state);
      end
      n_checks++;
      if (want !== rd) begin
        n_fail++;
        $display("FAIL err_mem_untouched kind%0d: got %h required %h", kind, want, rd);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_full();
    n_checks++;
    if (o_START !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_start: start=%b required 1", o_START);
    end
    #2 i_rstn = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({o_state, o_START, o_CALC_END, o_SAMPLE_COUNT} !== {LOAD, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset_calc: state=%0d start=%b calc_end=%b count=%0d, required 0/0/0/0",
               o_state, o_START, o_CALC_END, o_SAMPLE_COUNT);
    end
    tick();
    i_rstn = 1'b1;
    load_full();
    core_done();
    #2 i_rstn = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (o_CALC_END !== 1'b0 || o_state !== LOAD || o_DATA !== '0) begin
      n_fail++;
      $display("FAIL async_reset_result: calc_end=%b state=%0d data=%h, required 0/0/0", o_CALC_END, o_state, o_DATA);
    end
    tick();
    i_rstn = 1'b1;
    load_full();
    core_done();
    for (int idx = 0; idx < N; idx++) begin
      i_SAMPLE_INDEX = 12'(idx);
      #1;
      n_checks++;
      if (o_DATA !== ref_mem[idx]) begin
        n_fail++;
        $display("FAIL reload idx%0d: got %h required %h", idx, o_DATA, ref_mem[idx]);
      end
    end
    readout_exit();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd;
    for (int round = 0; round < 3; round++) begin
      int extra = $urandom_range(0, 4);
      for (int i = 0; i < N + extra; i++) begin
        int idx = (i < N) ? brev(i) : $urandom_range(0, N - 1);
        bridge_write(idx, 16'($urandom), i == N + extra - 1);
        n_checks++;
        if (o_SAMPLE_COUNT !== 4'(exp_count) || o_state !== exp_state) begin
          n_fail++;
          $display("FAIL b2b_count r%0d w%0d: count=%0d state=%0d, required %0d/%0d",
                   round, i, o_SAMPLE_COUNT, o_state, exp_count, exp_state);
        end
      end
      for (int i = 0; i < 8; i++) begin
        core_access($urandom_range(0, N - 1), 1'($urandom), $urandom, rd);
        n_checks++;
        if (o_CORE_RDATA !== rd) begin
          n_fail++;
          $display("FAIL b2b_core r%0d op%0d: got %h required %h", round, i, o_CORE_RDATA, rd);
        end
      end
      core_done();
      for (int i = 0; i < N; i++) begin
        int idx = $urandom_range(0, N - 1);
        i_SAMPLE_INDEX = 12'(idx);
        #1;
        n_checks++;
        if (o_DATA !== ref_mem[idx]) begin
          n_fail++;
          $display("FAIL b2b_read r%0d idx%0d: got %h required %h", round, idx, o_DATA, ref_mem[idx]);
        end
      end
      readout_exit();
      n_checks++;
      if ({o_state, o_SAMPLE_COUNT, o_ERR} !== {LOAD, 4'd0, exp_err}) begin
        n_fail++;
        $display("FAIL b2b_exit r%0d: state=%0d count=%0d err=%b, required 0/0/%b",
                 round, o_state, o_SAMPLE_COUNT, o_ERR, exp_err);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load();
    test_calc();
    test_result();
    test_bad_index();
    test_err_sources();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
